// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the memory-mapped countdown timer:
//   - register word offsets (bus_addr_i[4:2])
//   - CTRL bit positions and STATUS pending bit position
//   - timer FSM state encoding (STOP / RUN / DONE)
// -----------------------------------------------------------------------------
package timer_pkg;

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_LOAD     = 3'd1;
    localparam logic [2:0] REG_COUNT    = 3'd2;
    localparam logic [2:0] REG_STATUS   = 3'd3;
    localparam logic [2:0] REG_PRESCALE = 3'd4;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_IE  = 1;
    localparam int CTRL_AR  = 2;

    localparam int STATUS_PEND = 0;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

endpackage

// File: rtl/timer_prescaler.sv
// -----------------------------------------------------------------------------
// timer_prescaler
// Divides the clock into a tick every (div+1) clocks. Only instantiated by
// timer_irq_unit when TIMER_PRESCALE_EN is defined.
// Ports:
//   clk    in   single clock
//   reset  in   synchronous, active-high
//   clear  in   restarts the division period (counter back to 0)
//   div    in   16-bit divisor minus one
//   tick   out  high on the last clock of each period
// -----------------------------------------------------------------------------
module timer_prescaler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [15:0] div,
    output logic        tick
);

    logic [15:0] cnt_q;

    assign tick = (cnt_q == div);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q <= 16'd0;
        end else if (tick) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

endmodule

// File: rtl/timer_irq_unit.sv
// -----------------------------------------------------------------------------
// timer_irq_unit
// Memory-mapped countdown timer sitting beside data RAM on the CPU data bus.
// Expiry sets STATUS.pending; the interrupt is pending AND CTRL.ie and stays
// high until software writes 1 to STATUS.pending.
//
// Optional build macro: TIMER_PRESCALE_EN -- adds the PRESCALE register and a
// prescaler so the count ticks every PRESCALE+1 clocks instead of every clock.
//
// Ports:
//   clk                    in   single clock
//   reset                  in   synchronous, active-high
//   bus_addr_i[31:0]       in   byte address (window BASE_ADDR, 32 bytes)
//   bus_wdata_i[31:0]      in   write data
//   bus_we_i               in   write strobe
//   bus_en_i               in   access enable
//   bus_hit_o              out  enable and address inside the window
//   bus_rdata_o[31:0]      out  combinational read data, 0 unless read hit
//   req_interrupt_timer_o  out  level interrupt to the CPU
// -----------------------------------------------------------------------------
module timer_irq_unit
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] bus_addr_i,
    input  logic [31:0] bus_wdata_i,
    input  logic        bus_we_i,
    input  logic        bus_en_i,
    output logic        bus_hit_o,
    output logic [31:0] bus_rdata_o,
    output logic        req_interrupt_timer_o
);

    timer_state_t state_q, state_d;
    logic [2:0]   ctrl_q;
    logic [31:0]  load_q;
    logic [31:0]  count_q, count_d;
    logic         pend_q, pend_d;

    logic [2:0]   sel;
    logic         wr;
    logic         ctrl_wr, load_wr, count_wr, status_wr;
    logic         start, stop, run_tick, expire;
    logic         tick;
    logic [31:0]  pre_rd;

    // Byte lane bits are ignored: every access is a full word.
    logic         addr_unused;
    assign addr_unused = ^bus_addr_i[1:0];

    assign bus_hit_o = bus_en_i && (bus_addr_i[31:5] == BASE_ADDR[31:5]);
    assign sel       = bus_addr_i[4:2];
    assign wr        = bus_hit_o && bus_we_i;
    assign ctrl_wr   = wr && (sel == REG_CTRL);
    assign load_wr   = wr && (sel == REG_LOAD);
    assign count_wr  = wr && (sel == REG_COUNT);
    assign status_wr = wr && (sel == REG_STATUS);

    // Enabling from STOP or DONE reloads; enabling while running only
    // refreshes ie/autoreload.
    assign start = ctrl_wr && bus_wdata_i[CTRL_EN] && (state_q != RUN);
    assign stop  = ctrl_wr && !bus_wdata_i[CTRL_EN];

    // A COUNT write or a stop on this edge swallows the tick entirely.
    assign run_tick = (state_q == RUN) && tick && !stop && !count_wr;
    assign expire   = run_tick && (count_q == 32'd0);

`ifdef TIMER_PRESCALE_EN
    logic        pre_wr;
    logic        pre_clear;
    logic [15:0] pre_q;

    assign pre_wr    = wr && (sel == REG_PRESCALE);
    assign pre_clear = (state_q != RUN) || start || count_wr || pre_wr;
    assign pre_rd    = {16'd0, pre_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q <= 16'd0;
        end else if (pre_wr) begin
            pre_q <= bus_wdata_i[15:0];
        end
    end

    timer_prescaler u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (pre_clear),
        .div   (pre_q),
        .tick  (tick)
    );
`else
    assign tick   = 1'b1;
    assign pre_rd = 32'd0;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pend_d  = pend_q;

        if (run_tick) begin
            if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
            end else if (ctrl_q[CTRL_AR]) begin
                count_d = load_q;
            end else begin
                state_d = DONE;
            end
        end

        if (start) begin
            state_d = RUN;
            count_d = load_q;
        end
        if (stop) begin
            state_d = STOP;
        end
        if (count_wr) begin
            count_d = bus_wdata_i;
        end

        // Set after clear so an expiry on the clearing edge wins.
        if (status_wr && bus_wdata_i[STATUS_PEND]) begin
            pend_d = 1'b0;
        end
        if (expire) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= STOP;
            ctrl_q  <= 3'd0;
            load_q  <= 32'd0;
            count_q <= 32'd0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pend_q  <= pend_d;
            if (ctrl_wr) begin
                ctrl_q <= bus_wdata_i[2:0];
            end
            if (load_wr) begin
                load_q <= bus_wdata_i;
            end
        end
    end

    always_comb begin
        bus_rdata_o = 32'd0;
        if (bus_hit_o && !bus_we_i) begin
            case (sel)
                REG_CTRL:     bus_rdata_o = {29'd0, ctrl_q};
                REG_LOAD:     bus_rdata_o = load_q;
                REG_COUNT:    bus_rdata_o = count_q;
                REG_STATUS:   bus_rdata_o = {31'd0, pend_q};
                REG_PRESCALE: bus_rdata_o = pre_rd;
                default:      bus_rdata_o = 32'd0;
            endcase
        end
    end

    assign req_interrupt_timer_o = pend_q && ctrl_q[CTRL_IE];

endmodule

// File: tb/tb_timer_irq_unit.sv
// -----------------------------------------------------------------------------
// tb_timer_irq_unit
// Directed scenarios followed by randomized bus traffic. Every driven cycle
// pushes the expected combinational outputs (hit, read data, irq) computed
// from a behavioural model of the timer; a monitor pops and compares them on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_timer_irq_unit;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] bus_addr_i;
    logic [31:0] bus_wdata_i;
    logic        bus_we_i;
    logic        bus_en_i;
    logic        bus_hit_o;
    logic [31:0] bus_rdata_o;
    logic        req_interrupt_timer_o;

    always #5 clk = ~clk;

    timer_irq_unit #(.BASE_ADDR(BASE)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .bus_addr_i            (bus_addr_i),
        .bus_wdata_i           (bus_wdata_i),
        .bus_we_i              (bus_we_i),
        .bus_en_i              (bus_en_i),
        .bus_hit_o             (bus_hit_o),
        .bus_rdata_o           (bus_rdata_o),
        .req_interrupt_timer_o (req_interrupt_timer_o)
    );

    typedef struct packed {
        logic        hit;
        logic [31:0] rdata;
        logic        irq;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural model: mode 0 = stopped, 1 = counting, 2 = finished.
    bit          m_known = 0;
    int          m_mode;
    logic [2:0]  m_ctrl;
    logic [31:0] m_load;
    logic [31:0] m_count;
    logic        m_pend;
    logic [15:0] m_pre;
    int          m_since;

    function automatic logic [31:0] model_read(logic [2:0] sel);
        case (sel)
            3'd0: return {29'd0, m_ctrl};
            3'd1: return m_load;
            3'd2: return m_count;
            3'd3: return {31'd0, m_pend};
`ifdef TIMER_PRESCALE_EN
            3'd4: return {16'd0, m_pre};
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_edge(logic rst, logic en, logic we,
                                       logic [31:0] addr, logic [31:0] wdata);
        logic       hit, wr, tick, stop_w, start_w, cnt_w, pre_w, counting, expired;
        logic [2:0] sel;
        if (rst) begin
            m_mode = 0; m_ctrl = 0; m_load = 0; m_count = 0; m_pend = 0;
            m_pre = 0; m_since = 0; m_known = 1;
            return;
        end
        if (!m_known) return;
        hit     = en && (addr[31:5] == BASE[31:5]);
        wr      = hit && we;
        sel     = addr[4:2];
        tick    = 1'b1;
`ifdef TIMER_PRESCALE_EN
        tick    = (m_since == int'(m_pre));
`endif
        stop_w  = wr && sel == 3'd0 && !wdata[0];
        start_w = wr && sel == 3'd0 && wdata[0] && m_mode != 1;
        cnt_w   = wr && sel == 3'd2;
        pre_w   = wr && sel == 3'd4;
        counting = (m_mode == 1) && tick && !stop_w && !cnt_w;
        expired  = counting && m_count == 0;

        if (m_mode != 1 || start_w || cnt_w || pre_w || tick) m_since = 0;
        else m_since = m_since + 1;

        if (counting && m_count != 0) m_count = m_count - 1;
        if (expired) begin
            if (m_ctrl[2]) m_count = m_load;
            else m_mode = 2;
        end
        if (wr && sel == 3'd3 && wdata[0]) m_pend = 0;
        if (expired) m_pend = 1;
        if (start_w) begin
            m_mode  = 1;
            m_count = m_load;
        end
        if (stop_w) m_mode = 0;
        if (wr && sel == 3'd0) m_ctrl = wdata[2:0];
        if (wr && sel == 3'd1) m_load = wdata;
        if (cnt_w) m_count = wdata;
`ifdef TIMER_PRESCALE_EN
        if (pre_w) m_pre = wdata[15:0];
`endif
    endfunction

    logic        s_hit;
    logic [31:0] s_rd;
    logic        s_irq;

    task automatic do_cycle(input logic rst, input logic en, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        reset       = rst;
        bus_en_i    = en;
        bus_we_i    = we;
        bus_addr_i  = addr;
        bus_wdata_i = wdata;
        if (m_known) begin
            e.hit   = en && (addr[31:5] == BASE[31:5]);
            e.rdata = (e.hit && !we) ? model_read(addr[4:2]) : 32'd0;
            e.irq   = m_pend && m_ctrl[1];
            exp_q.push_back(e);
        end
        #1;
        s_hit = bus_hit_o;
        s_rd  = bus_rdata_o;
        s_irq = req_interrupt_timer_o;
        @(posedge clk);
        model_edge(rst, en, we, addr, wdata);
        #1;
    endtask

    task automatic idle();
        do_cycle(1'b0, 1'b0, 1'b0, $urandom, $urandom);
    endtask

    task automatic wr_reg(input int sel, input logic [31:0] data);
        do_cycle(1'b0, 1'b1, 1'b1, BASE + 32'(sel * 4) + 32'($urandom_range(0, 3)), data);
    endtask

    task automatic rd_reg(input int sel);
        do_cycle(1'b0, 1'b1, 1'b0, BASE + 32'(sel * 4) + 32'($urandom_range(0, 3)), $urandom);
    endtask

    // Monitor: compare every presented cycle against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_hit", {31'd0, bus_hit_o}, {31'd0, e.hit});
                check("sb_rdata", bus_rdata_o, e.rdata);
                check("sb_irq", {31'd0, req_interrupt_timer_o}, {31'd0, e.irq});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        int sel;
        logic [31:0] d;

        // Reset and idle state
        repeat (3) do_cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        idle();
        check("rst_irq", {31'd0, req_interrupt_timer_o}, 32'd0);
        do_cycle(1'b0, 1'b0, 1'b0, BASE, 32'd0);
        check("rst_hit_en0", {31'd0, s_hit}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            rd_reg(i);
            check($sformatf("rst_read_%0d", i), s_rd, 32'd0);
        end

        // One-shot: LOAD=3, CTRL=ie|en
        wr_reg(1, 32'd3);
        wr_reg(0, 32'd3);
        for (int i = 1; i <= 4; i++) begin
            idle();
            check($sformatf("oneshot_irq_edge%0d", i), {31'd0, req_interrupt_timer_o},
                  (i == 4) ? 32'd1 : 32'd0);
        end
        rd_reg(2);
        check("oneshot_count0", s_rd, 32'd0);
        wr_reg(3, 32'd1);
        check("oneshot_clear", {31'd0, req_interrupt_timer_o}, 32'd0);
        repeat (6) idle();
        check("oneshot_done_quiet", {31'd0, req_interrupt_timer_o}, 32'd0);

        // Autoreload: LOAD=2, CTRL=7, period 3; clear on expiry edge loses
        wr_reg(1, 32'd2);
        wr_reg(0, 32'd7);
        repeat (3) idle();
        check("auto_first", {31'd0, req_interrupt_timer_o}, 32'd1);
        repeat (2) idle();
        wr_reg(3, 32'd1);
        check("auto_set_wins", {31'd0, req_interrupt_timer_o}, 32'd1);
        wr_reg(3, 32'd1);
        check("auto_cleared", {31'd0, req_interrupt_timer_o}, 32'd0);
        repeat (2) idle();
        check("auto_third", {31'd0, req_interrupt_timer_o}, 32'd1);

        // COUNT override while running
        wr_reg(0, 32'd0);
        wr_reg(3, 32'd1);
        wr_reg(1, 32'd20);
        wr_reg(0, 32'd3);
        idle();
        wr_reg(2, 32'd10);
        idle();
        rd_reg(2);
        check("count_override", s_rd, 32'd9);

        // LOAD written mid-run applies at next reload
        wr_reg(0, 32'd0);
        wr_reg(3, 32'd1);
        wr_reg(1, 32'd2);
        wr_reg(0, 32'd7);
        wr_reg(1, 32'd5);
        repeat (2) idle();
        check("midload_expiry", {31'd0, req_interrupt_timer_o}, 32'd1);
        rd_reg(2);
        check("midload_reload", s_rd, 32'd5);

        // Masking with ie, reserved reads, out-of-window access
        wr_reg(0, 32'd0);
        wr_reg(3, 32'd1);
        wr_reg(1, 32'd0);
        wr_reg(0, 32'd1);
        idle();
        check("masked_irq", {31'd0, req_interrupt_timer_o}, 32'd0);
        rd_reg(3);
        check("masked_pending", s_rd, 32'd1);
        wr_reg(0, 32'd2);
        check("unmask_irq", {31'd0, req_interrupt_timer_o}, 32'd1);
        rd_reg(6);
        check("reserved_read", s_rd, 32'd0);
        do_cycle(1'b0, 1'b1, 1'b0, BASE + 32'h20, 32'd0);
        check("outside_hit", {31'd0, s_hit}, 32'd0);
        check("outside_rdata", s_rd, 32'd0);

`ifdef TIMER_PRESCALE_EN
        wr_reg(0, 32'd0);
        wr_reg(3, 32'd1);
        wr_reg(4, 32'd1);
        wr_reg(1, 32'd1);
        wr_reg(0, 32'd3);
        for (int i = 1; i <= 4; i++) begin
            idle();
            check($sformatf("prescale_irq_edge%0d", i), {31'd0, req_interrupt_timer_o},
                  (i == 4) ? 32'd1 : 32'd0);
        end
        rd_reg(4);
        check("prescale_read", s_rd, 32'd1);
`else
        wr_reg(4, 32'h0000_0005);
        rd_reg(4);
        check("prescale_absent", s_rd, 32'd0);
`endif

        // Reset mid-operation
        wr_reg(1, 32'd7);
        wr_reg(0, 32'd7);
        idle();
        do_cycle(1'b1, 1'b1, 1'b1, BASE, 32'd7);
        check("midrst_irq", {31'd0, req_interrupt_timer_o}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            rd_reg(i);
            check($sformatf("midrst_read_%0d", i), s_rd, 32'd0);
        end

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 1) begin
                do_cycle(1'b1, 1'b0, 1'b0, $urandom, $urandom);
            end else if (r < 50) begin
                idle();
            end else if (r < 56) begin
                do_cycle(1'b0, 1'b1, 1'($urandom), BASE + 32'h20 + ($urandom & 32'h0FF0_FFE0), $urandom);
            end else if (r < 75) begin
                rd_reg($urandom_range(0, 7));
            end else begin
                sel = $urandom_range(0, 7);
                case (sel)
                    1:       d = 32'($urandom_range(0, 6));
                    2:       d = 32'($urandom_range(0, 8));
                    4:       d = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 3));
                    default: d = $urandom;
                endcase
                wr_reg(sel, d);
            end
        end

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
